alu_seq: RTL and testbench

- Parametrised, handshaked successor to the processor's combinational 32-bit ALU.
- Single-cycle ops (add/sub/logic/shift/compare) return after one registered stage.
- MUL, and DIVU/REMU when enabled, run on an iterative unit taking WIDTH cycles.
- Sits between decode/issue and writeback.
- Results and NZCV-style flags are registered and held until the consumer accepts them.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_seq_muldiv.sv | 92 +++++++++
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// alu_seq_pkg: opcode/state types and helpers for alu_seq (rev 1.0).
// Honours ALU_SEQ_DIV_EN: when undefined, DIVU/REMU are not iterative (treated as illegal).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_SUB  = 4'b0000,
    OP_MUL  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_LTU  = 4'b0100,
    OP_LEU  = 4'b0101,
    OP_EQ   = 4'b0110,
    OP_ADD  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_SLL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_DIVU = 4'b1100,
    OP_REMU = 4'b1101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Replicated to WIDTH bits by the datapath for illegal opcodes.
  localparam logic OP_ILLEGAL_RESULT = 1'b0;

  function automatic logic is_iterative(input op_e op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// alu_seq_muldiv: WIDTH-cycle shift-add multiplier / restoring divider (rev 1.0).
// Divider path exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_count;
  logic             r_running;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // Pulses on the final iteration so the caller can leave BUSY on the same edge.
  assign done = r_running && (r_count == CW'(WIDTH - 1));

`ifdef ALU_SEQ_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic             unused_div_diff_bit;
  assign unused_div_diff_bit = w_div_diff[WIDTH];
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_comb begin
    // Multiply: {hi,lo} shifts right, conditionally adding the multiplicand into hi.
    w_mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, r_opb} : '0);
    w_hi_next = w_mul_sum[WIDTH:1];
    w_lo_next = {w_mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    w_div_shift = {hi, lo[WIDTH-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    if (r_div) begin
      w_lo_next = {lo[WIDTH-2:0], ~w_div_diff[WIDTH+1]};
      w_hi_next = w_div_diff[WIDTH+1] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      r_opb     <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      div0      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_div     <= 1'b0;
`endif
    end else if (start) begin
      hi        <= '0;
      lo        <= a;
      r_opb     <= b;
      r_count   <= '0;
      r_running <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      r_div     <= is_div;
      div0      <= is_div && (b == '0);
`else
      div0      <= 1'b0;
`endif
    end else if (r_running) begin
      hi      <= w_hi_next;
      lo      <= w_lo_next;
      r_count <= r_count + CW'(1);
      if (done) begin
        r_running <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// alu_seq: handshaked ALU with registered result/NZCV flags; MUL (and DIVU/REMU
// when ALU_SEQ_DIV_EN is defined) run on an iterative unit (rev 1.0).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  state_e state, next_state;
  op_e    op_in;
  logic   accept;
  logic   op_iter;

  logic             md_done;
  logic             md_div0;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_ovf, r_zero, r_neg;
  logic             r_iter, r_is_div, r_swap;

  assign op_in   = op_e'(op);
  assign op_iter = is_iterative(op_in);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = op_iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (md_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Consuming a result frees the unit in the same cycle for back-to-back issue.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            next_state = op_iter ? BUSY : DONE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_diff  = {1'b0, a} - {1'b0, b};
    w_shamt = b[SHW-1:0];
    w_res   = {WIDTH{OP_ILLEGAL_RESULT}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op_in)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  w_res = a | b;
      OP_AND: w_res = a & b;
      OP_XOR: w_res = a ^ b;
      OP_SRL: w_res = a >> w_shamt;
      OP_SLL: w_res = a << w_shamt;
      OP_SRA: w_res = $signed(a) >>> w_shamt;
      OP_LTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LEU: w_res = {{(WIDTH-1){1'b0}}, (a <= b)};
      OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      // Illegal opcodes (and DIVU/REMU without the divider) land here.
      default: w_ovf = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_iter   <= 1'b0;
      r_is_div <= 1'b0;
      r_swap   <= 1'b0;
    end else if (accept) begin
      if (op_iter) begin
        r_iter   <= 1'b1;
        r_is_div <= (op_in != OP_MUL);
        r_swap   <= (op_in == OP_REMU);
      end else begin
        r_iter   <= 1'b0;
        r_result <= w_res;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
        r_zero   <= (w_res == '0);
        r_neg    <= w_res[WIDTH-1];
      end
    end
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && op_iter),
    .is_div (op_in != OP_MUL),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi),
    .div0   (md_div0)
  );

  // Iterative results are read straight from the unit's registers, which hold once it stops.
  always_comb begin
    result    = r_result;
    result_hi = '0;
    carry     = r_carry;
    overflow  = r_ovf;
    zero      = r_zero;
    negative  = r_neg;
    if (r_iter) begin
      result    = r_swap ? md_hi : md_lo;
      result_hi = r_swap ? md_lo : md_hi;
      carry     = 1'b0;
      overflow  = r_is_div ? md_div0 : (md_hi != '0);
      zero      = (result == '0);
      negative  = result[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq: scoreboard bench for alu_seq (rev 1.0).
// Expectations for DIVU/REMU follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, overflow, zero, negative, busy;
  logic [W-1:0] result, result_hi;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c, v, z, n;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   head_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, s;
    longint unsigned ux, uy, p;
    e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      4'h0: begin
        e.res = x - y; e.c = (x >= y); s = sx - sy;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        p = ux * uy; e.res = p[31:0]; e.hi = p[63:32]; e.v = (e.hi != 0); e.lat = W + 1;
      end
      4'h2: e.res = x | y;
      4'h3: e.res = x >> y[4:0];
      4'h4: e.res = (x < y) ? 32'd1 : 32'd0;
      4'h5: e.res = (x <= y) ? 32'd1 : 32'd0;
      4'h6: e.res = (x == y) ? 32'd1 : 32'd0;
      4'h7: begin
        e.res = x + y; e.c = ((ux + uy) >= 64'h1_0000_0000); s = sx + sy;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h8: e.res = x & y;
      4'h9: e.res = x ^ y;
      4'hA: e.res = x << y[4:0];
      4'hB: e.res = $signed(x) >>> y[4:0];
`ifdef ALU_SEQ_DIV_EN
      4'hC, 4'hD: begin
        logic [W-1:0] q, r;
        if (y == 0) begin q = '1; r = x; e.v = 1'b1; end
        else begin q = x / y; r = x % y; end
        e.res = (o == 4'hC) ? q : r;
        e.hi  = (o == 4'hC) ? r : q;
        e.lat = W + 1;
      end
`endif
      default: e.v = 1'b1;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // Monitor: compares on out_valid&&out_ready, pushes expectations on in_valid&&in_ready.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (busy) begin
        check("busy_in_ready", in_ready, 0);
        check("busy_out_valid", out_valid, 0);
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!head_seen) begin
            check("latency", cyc, sbq[0].acc + sbq[0].lat);
            head_seen = 1'b1;
          end
          if (!out_ready) begin
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, sbq[0].res);
          end else begin
            check("result", result, sbq[0].res);
            check("result_hi", result_hi, sbq[0].hi);
            check("carry", carry, sbq[0].c);
            check("overflow", overflow, sbq[0].v);
            check("zero", zero, sbq[0].z);
            check("negative", negative, sbq[0].n);
            void'(sbq.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(op, a, b);
        e.acc = cyc;
        sbq.push_back(e);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output time acc_t);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_timeout", in_ready, 1);
    acc_t = $time;
    @(posedge clk);
    #1;
    // Operands are scrambled after acceptance; the DUT must not resample them.
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 64'(sbq.size()), 0);
      sbq.delete();
      head_seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0]   t_op [10] = '{4'h5, 4'h6, 4'h3, 4'hA, 4'hB, 4'h8, 4'h9, 4'h7, 4'h0, 4'h2};
  logic [W-1:0] t_a  [10] = '{32'd5, 32'hDEAD, 32'h8000_0000, 32'h1, 32'h8000_0000,
                              32'hF0F0_1234, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'd1, 32'h0};
  logic [W-1:0] t_b  [10] = '{32'd5, 32'hDEAD, 32'd35, 32'd31, 32'd4,
                              32'h0FF0_FFFF, 32'h0F0F_0F0F, 32'd1, 32'd2, 32'h0};
  logic [3:0]   r_ops [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  initial begin
    time t0, t1, t2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", {carry, overflow, zero, negative}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    issue(4'h7, 32'hFFFF_FFFF, 32'd1, t0);
    issue(4'h0, 32'h8000_0000, 32'd1, t0);
    issue(4'h4, 32'd3, 32'd5, t0);
    drain();
    for (int i = 0; i < 10; i++) issue(t_op[i], t_a[i], t_b[i], t0);
    drain();

    issue(4'h1, 32'h0001_0000, 32'h0001_0000, t0);
    drain();
    issue(4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
    issue(4'h1, 32'd12345, 32'd678, t0);
    drain();

    issue(4'h2, 32'h1, 32'h2, t0);
    issue(4'h2, 32'h10, 32'h20, t1);
    issue(4'h2, 32'h100, 32'h200, t2);
    check("b2b_gap1", t1 - t0, 10);
    check("b2b_gap2", t2 - t1, 10);
    issue(4'h2, 32'hA5A5_0000, 32'h0000_5A5A, t0);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    issue(4'hC, 32'd100, 32'd7, t0);
    issue(4'hC, 32'd9, 32'd0, t0);
    issue(4'hD, 32'd100, 32'd7, t0);
    issue(4'hE, 32'd1, 32'd1, t0);
    issue(4'hF, 32'hFFFF, 32'h1, t0);
    drain();

    issue(4'h1, 32'hABCD_1234, 32'h0000_F00D, t0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_result_hi", result_hi, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_flags", {carry, overflow, zero, negative}, 0);
    sbq.delete();
    head_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'h7, 32'd2, 32'd3, t0);
    drain();

    for (int i = 0; i < 24; i++) begin
      issue(r_ops[$urandom_range(15)], $urandom, (i % 3 == 0) ? 32'($urandom_range(40)) : $urandom, t0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
